// File: rtl/tb_uart_pkg.sv
// ---------------------------------------------------------------------------
// tb_uart_pkg
// Shared definitions for the UART receive monitor:
//   rx_state_t            - receiver FSM state encoding (IDLE/START/DATA/STOP)
//   ASCII_LF, ASCII_CR    - line-control characters
//   DEFAULT_CLKS_PER_BIT  - default oversampling ratio
// No ports (package).
// ---------------------------------------------------------------------------
package tb_uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/tb_uart_rx_monitor_if.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_monitor_if
// Byte stream from the UART receive monitor to its consumer.
//   o_data  - head-of-FIFO byte (0 while o_valid is low)
//   o_valid - o_data holds a byte
//   i_ready - consumer can take the byte
// Handshake: a byte transfers on every rising clock edge where
// o_valid && i_ready. While o_valid && !i_ready, o_data holds steady and
// o_valid stays high; o_valid never depends on i_ready.
// Modports: master = monitor side, slave = consumer side.
// ---------------------------------------------------------------------------
interface tb_uart_rx_monitor_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;

    modport master (output o_data, output o_valid, input i_ready);
    modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   push        - write request with push_data
//   pop         - read request (ignored when empty)
//   rd_data     - head entry, 0 when empty
//   valid       - FIFO holds at least one entry
//   level       - occupancy 0..DEPTH
//   push_ok     - push was accepted this cycle
//   drop        - push was refused (full, no simultaneous pop)
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int LVL_W = 5,
    parameter int W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     rd_data,
    output logic             valid,
    output logic [LVL_W-1:0] level,
    output logic             push_ok,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign valid   = (level != '0);
    assign pop_ok  = pop && valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/tb_uart_rx_monitor.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_monitor
// Oversampling 8N1 UART receiver feeding a FWFT byte FIFO.
// Optional build macro: TB_UART_RX_LINE_DETECT_EN (adds line-feed counting).
// Ports:
//   clk_uart, clk_uart_rst - sampling clock, synchronous active-high reset
//   i_uart_rxd             - asynchronous serial input, idle high
//   bus                    - byte stream out (o_data/o_valid/i_ready)
//   o_level                - FIFO occupancy
//   o_framing_err          - sticky, stop bit sampled low
//   o_overflow             - sticky, byte arrived while FIFO full
//   i_clear_err            - pulse clears both sticky flags (set wins)
//   o_dbg_state            - current receiver FSM state
//   o_line_done/o_line_count - (macro only) LF pushed pulse / saturating count
// ---------------------------------------------------------------------------
module tb_uart_rx_monitor
    import tb_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16,
    parameter int LVL_W        = 5
) (
    input  logic                 clk_uart,
    input  logic                 clk_uart_rst,
    input  logic                 i_uart_rxd,
    tb_uart_rx_monitor_if.master bus,
    output logic [LVL_W-1:0]     o_level,
    output logic                 o_framing_err,
    output logic                 o_overflow,
    input  logic                 i_clear_err,
`ifdef TB_UART_RX_LINE_DETECT_EN
    output logic                 o_line_done,
    output logic [15:0]          o_line_count,
`endif
    output rx_state_t            o_dbg_state
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rxd_m, rxd_s;
    rx_state_t        state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             armed;
    logic             cnt_half, cnt_full;
    logic             push_req, frame_evt;
    logic             push_ok, drop;

    assign o_dbg_state = state;
    assign cnt_half    = (cnt == HALF_LAST);
    assign cnt_full    = (cnt == BIT_LAST);

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk_uart) begin
        if (clk_uart_rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= i_uart_rxd;
            rxd_s <= rxd_m;
        end
    end

    // FSM: state register
    always_ff @(posedge clk_uart) begin
        if (clk_uart_rst) state <= RX_IDLE;
        else              state <= next_state;
    end

    // FSM: next state
    always_comb begin
        next_state = state;
        case (state)
            RX_IDLE:  if (armed && !rxd_s)             next_state = RX_START;
            RX_START: if (cnt_half)                    next_state = rxd_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_full && bit_idx == 3'd7) next_state = RX_STOP;
            RX_STOP:  if (cnt_full)                    next_state = RX_IDLE;
            default:                                   next_state = RX_IDLE;
        endcase
    end

    // FSM: outputs (events raised at the mid-stop-bit sample)
    always_comb begin
        push_req  = 1'b0;
        frame_evt = 1'b0;
        if (state == RX_STOP && cnt_full) begin
            push_req  = rxd_s;
            frame_evt = !rxd_s;
        end
    end

    // Bit timing, shift register and arming. The counter always wraps by
    // compare-and-clear so CLKS_PER_BIT need not be a power of two.
    always_ff @(posedge clk_uart) begin
        if (clk_uart_rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            armed   <= 1'b0;
        end else begin
            // Disarm after a bad stop bit so a held-low break cannot look
            // like a stream of start bits; re-arm once the line is high.
            if (frame_evt)  armed <= 1'b0;
            else if (rxd_s) armed <= 1'b1;

            case (state)
                RX_IDLE: cnt <= '0;
                RX_START: begin
                    cnt     <= cnt_half ? '0 : cnt + CNT_W'(1);
                    bit_idx <= '0;
                end
                RX_DATA: begin
                    if (cnt_full) begin
                        cnt     <= '0;
                        shreg   <= {rxd_s, shreg[7:1]};  // LSB arrives first
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: cnt <= cnt_full ? '0 : cnt + CNT_W'(1);
                default: cnt <= '0;
            endcase
        end
    end

    tb_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W),
        .W     (8)
    ) u_fifo (
        .clk       (clk_uart),
        .rst       (clk_uart_rst),
        .push      (push_req),
        .push_data (shreg),
        .pop       (bus.o_valid && bus.i_ready),
        .rd_data   (bus.o_data),
        .valid     (bus.o_valid),
        .level     (o_level),
        .push_ok   (push_ok),
        .drop      (drop)
    );

    // Sticky flags: a new event in the same cycle as a clear wins.
    always_ff @(posedge clk_uart) begin
        if (clk_uart_rst) begin
            o_framing_err <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            if (frame_evt)        o_framing_err <= 1'b1;
            else if (i_clear_err) o_framing_err <= 1'b0;
            if (drop)             o_overflow    <= 1'b1;
            else if (i_clear_err) o_overflow    <= 1'b0;
        end
    end

`ifdef TB_UART_RX_LINE_DETECT_EN
    // Only bytes that actually entered the FIFO count as line ends.
    always_ff @(posedge clk_uart) begin
        if (clk_uart_rst) begin
            o_line_done  <= 1'b0;
            o_line_count <= '0;
        end else begin
            o_line_done <= push_ok && (shreg == ASCII_LF);
            if (push_ok && shreg == ASCII_LF && o_line_count != 16'hFFFF) begin
                o_line_count <= o_line_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_tb_uart_rx_monitor.sv
// ---------------------------------------------------------------------------
// tb_tb_uart_rx_monitor
// Bench for tb_uart_rx_monitor: serial frames are driven bit by bit, the
// expected byte stream and flag state are kept in a simple queue model, and
// a monitor pops and compares each byte the DUT hands over.
// ---------------------------------------------------------------------------
module tb_tb_uart_rx_monitor;
    import tb_uart_pkg::*;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int LVL_W = 5;

    logic             clk_uart = 1'b0;
    logic             rst      = 1'b1;
    logic             rxd      = 1'b1;
    logic             clear_err = 1'b0;
    logic [LVL_W-1:0] level;
    logic             ferr;
    logic             ovf;
    rx_state_t        dbg_state;
`ifdef TB_UART_RX_LINE_DETECT_EN
    logic             line_done;
    logic [15:0]      line_count;
`endif

    tb_uart_rx_monitor_if bus ();

    tb_uart_rx_monitor #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .LVL_W        (LVL_W)
    ) dut (
        .clk_uart      (clk_uart),
        .clk_uart_rst  (rst),
        .i_uart_rxd    (rxd),
        .bus           (bus),
        .o_level       (level),
        .o_framing_err (ferr),
        .o_overflow    (ovf),
        .i_clear_err   (clear_err),
`ifdef TB_UART_RX_LINE_DETECT_EN
        .o_line_done   (line_done),
        .o_line_count  (line_count),
`endif
        .o_dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk_uart = ~clk_uart;

    // ---------------- model / counters ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         model_level = 0;
    int         exp_ovf     = 0;
    int         exp_lines   = 0;
    int         valid_cycles = 0;
    int         line_pulses  = 0;
    bit         rand_ready  = 1'b0;
    logic       ready_fixed = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_uart);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        idle(CPB);
    endtask

    // Model of a correctly framed byte reaching the receiver: a 16-entry
    // buffer that drops on full; LF bytes that get stored count as lines.
    task automatic expect_byte(input logic [7:0] b);
        if (model_level < DEPTH) begin
            exp_q.push_back(b);
            model_level++;
            if (b == 8'h0A) exp_lines++;
        end else begin
            exp_ovf = 1;
        end
    endtask

    // Full 8N1 frame; the expectation is queued before the stop bit is
    // sampled so the monitor always finds it.
    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (stop_val) expect_byte(b);
        drive_bit(stop_val);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
        idle(2);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) idle(1);
        idle(4);
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- ready driver ----------------
    initial begin
        bus.i_ready = 1'b0;
        forever begin
            @(posedge clk_uart);
            #1;
            bus.i_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_uart) begin
        if (!rst) begin
            if (bus.o_valid) valid_cycles++;
`ifdef TB_UART_RX_LINE_DETECT_EN
            if (line_done) line_pulses++;
`endif
            if (bus.o_valid && bus.i_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got %02h expected none", bus.o_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    model_level--;
                    if (bus.o_data !== e) begin
                        n_fail++;
                        $display("FAIL byte: got %02h expected %02h", bus.o_data, e);
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] hello [6];
        logic [7:0] b;
        int         non_idle;
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};

        idle(3);
        rst = 1'b0;
        idle(2);
        // reset state
        check("rst_valid", bus.o_valid, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_level", level, 0);
        check("rst_ferr", ferr, 0);
        check("rst_ovf", ovf, 0);
        check("rst_state", dbg_state, RX_IDLE);
`ifdef TB_UART_RX_LINE_DETECT_EN
        check("rst_line_done", line_done, 0);
        check("rst_line_count", line_count, 0);
`endif
        idle(10);

        // 1: single byte, consumer always ready
        ready_fixed  = 1'b1;
        valid_cycles = 0;
        send_byte(8'h48, 1'b1);
        idle(20);
        check("t1_valid_cycles", valid_cycles, 1);
        check("t1_drain", exp_q.size(), 0);
        check("t1_ferr", ferr, 0);
        check("t1_ovf", ovf, 0);

        // 2: "Hello\n" buffered, then drained in order
        ready_fixed = 1'b0;
        idle(2);
        foreach (hello[i]) begin
            send_byte(hello[i], 1'b1);
            idle(2);
        end
        idle(10);
        check("t2_level", level, 6);
        check("t2_valid", bus.o_valid, 1);
        check("t2_head_hold", bus.o_data, 8'h48);
        ready_fixed = 1'b1;
        wait_drain("t2_drain");
        check("t2_level_empty", level, 0);
`ifdef TB_UART_RX_LINE_DETECT_EN
        check("t2_line_pulses", line_pulses, exp_lines);
        check("t2_line_count", line_count, exp_lines);
`endif

        // 3: overflow with 17 bytes into a 16-entry FIFO
        ready_fixed = 1'b0;
        idle(2);
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1);
            idle($urandom_range(0, 6));
        end
        idle(10);
        check("t3_level_full", level, model_level);
        check("t3_ovf", ovf, exp_ovf);
        ready_fixed = 1'b1;
        wait_drain("t3_drain");
        check("t3_ovf_sticky", ovf, 1);
        pulse_clear();
        exp_ovf = 0;
        check("t3_ovf_cleared", ovf, exp_ovf);

        // 4: framing error followed by a held-low break
        send_byte(8'h55, 1'b0);
        non_idle = 0;
        for (int i = 0; i < 40; i++) begin
            if (dbg_state != RX_IDLE) non_idle++;
            idle(1);
        end
        check("t4_ferr", ferr, 1);
        check("t4_no_push", level, 0);
        check("t4_break_no_start", non_idle, 0);
        rxd = 1'b1;
        idle(20);
        send_byte(8'hA5, 1'b1);
        idle(20);
        check("t4_a5_drain", exp_q.size(), 0);
        check("t4_ferr_sticky", ferr, 1);
        pulse_clear();
        check("t4_ferr_cleared", ferr, 0);

        // 5: short low glitch on idle line
        valid_cycles = 0;
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(30);
        check("t5_state", dbg_state, RX_IDLE);
        check("t5_no_valid", valid_cycles, 0);
        check("t5_ferr", ferr, 0);
        check("t5_ovf", ovf, 0);

        // 6: reset in the middle of a data bit
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        check("t6_mid_data", dbg_state, RX_DATA);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rxd = 1'b1;
        exp_q.delete();
        model_level = 0;
        exp_ovf     = 0;
        exp_lines   = 0;
        valid_cycles = 0;
        idle(30);
        check("t6_level", level, 0);
        check("t6_no_valid", valid_cycles, 0);
        check("t6_state", dbg_state, RX_IDLE);
        send_byte(8'h3C, 1'b1);
        idle(20);
        check("t6_3c_drain", exp_q.size(), 0);

        // random bytes with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) b = 8'h0A;
            send_byte(b, 1'b1);
            idle($urandom_range(0, 10));
        end
        rand_ready  = 1'b0;
        ready_fixed = 1'b1;
        wait_drain("rand_drain");
        check("rand_level", level, 0);
        check("rand_ovf", ovf, exp_ovf);
        check("rand_ferr", ferr, 0);
`ifdef TB_UART_RX_LINE_DETECT_EN
        check("rand_line_count", line_count, exp_lines);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tb_uart_rx_monitor.md
Name: tb_uart_rx_monitor

Overview:
Synthesizable-style UART receive monitor that sits directly downstream of the system UART0 transmit pin (`uart0_rx` net) in the Verilator hello_world bench.
- Oversamples the serial line on `clk_uart`, deframes 8N1 characters and buffers them in a small FIFO.
- Hands bytes to the bench log/checker over a valid/ready interface.
- Replaces ad-hoc character scraping, giving the bench a cycle-accurate, checkable byte stream with error flags.

Parameters:
- CLKS_PER_BIT, 16, `clk_uart` cycles per UART bit period; must be ≥4 and even.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, ≥2.
- LVL_W, 5, width of the level output; equals log2(FIFO_DEPTH)+1.

Ports:
- clk_uart  input  1  sampling clock, CLKS_PER_BIT × baud.
- clk_uart_rst  input  1  reset: one clock, synchronous, active-high.
- i_uart_rxd  input  1  serial line from DUT, idle high, asynchronous to `clk_uart`.
- o_data  output  8  head-of-FIFO byte.
- o_valid  output  1  `o_data` holds a byte.
- i_ready  input  1  consumer accepts the byte when `o_valid && i_ready`.
- o_level  output  LVL_W  current FIFO occupancy, 0..FIFO_DEPTH.
- o_framing_err  output  1  sticky: stop bit sampled low.
- o_overflow  output  1  sticky: byte arrived while FIFO full.
- i_clear_err  input  1  one-cycle pulse; clears both sticky flags.

Behaviour:
- **Reset values.** All outputs 0. FSM in IDLE, disarmed. Synchronizer flops 1. FIFO empty.
- **Input synchronizer.** `i_uart_rxd` passes through 2 flops giving `rxd_s`. Every decision uses `rxd_s`, so there is 2 cycles of input latency.
- **Arming.** An `armed` bit is set when `rxd_s` = 1 and cleared on entry to IDLE after a framing error. This prevents a held-low break from re-triggering reception.
- **FSM states and transitions:**
  - IDLE: if `armed && rxd_s == 0` → START, bit counter = 0.
  - START: counts to CLKS_PER_BIT/2−1. If `rxd_s` = 0 there → DATA, counter = 0, bit index = 0. Otherwise (glitch) → IDLE with no flag set.
  - DATA: samples `rxd_s` every CLKS_PER_BIT cycles (mid-bit). The bit is shifted in at MSB with a right shift, so data arrives LSB first. After bit index 7 → STOP.
  - STOP: samples after CLKS_PER_BIT cycles.
    - `rxd_s` = 1: push the byte to the FIFO, go to IDLE.
    - `rxd_s` = 0: set `o_framing_err`, discard the byte, disarm, go to IDLE.
- **Counter width.** The counter is clog2(CLKS_PER_BIT) bits and wraps by explicit compare-and-clear, never by overflow.
- **FIFO interface.** First-word-fall-through.
  - A push into an empty FIFO gives `o_valid` = 1 on the next cycle.
  - A pop occurs on `o_valid && i_ready`. `o_data` is stable while `o_valid && !i_ready`.
- **FIFO boundary conditions:**
  - Push while full with no pop: byte dropped, `o_overflow` set, contents unchanged.
  - Push and pop in the same cycle while full: both accepted, level unchanged.
  - Push and pop in the same cycle while empty: not possible, since `o_valid` = 0.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
  - `o_level` = pushes − pops.
- **Flag clear.** If `i_clear_err` coincides with a new error event, the set wins.
- **Reset mid-character.** Returns the FSM to IDLE and empties the FIFO. No partial byte is emitted after reset.

Optional Feature:
- Macro: TB_UART_RX_LINE_DETECT_EN.
- Defined: adds `o_line_done` (1-bit) and `o_line_count` (16-bit).
  - `o_line_done` pulses for 1 cycle on the cycle after a 0x0A byte is pushed. Dropped bytes do not count.
  - `o_line_count` increments at the same time and saturates at 0xFFFF.
  - Both reset to 0.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package `tb_uart_pkg` holds:
  - RX state encoding: IDLE=0, START=1, DATA=2, STOP=3.
  - ASCII constants: LF=8'h0A, CR=8'h0D.
  - Default CLKS_PER_BIT.
- One sub-module, `tb_uart_rx_fifo` (parameterized sync FIFO, FWFT, full/empty/level). The top holds the synchronizer, FSM and flags.

Test Plan:
1. Send 0x48 ('H') at 16 clk/bit, `i_ready` = 1. Expect `o_valid` for exactly 1 cycle with `o_data` = 0x48, and no flags.
2. Send "Hello\n" with `i_ready` = 0. Expect `o_level` = 6, then 6 pops in order 48 65 6C 6C 6F 0A. With TB_UART_RX_LINE_DETECT_EN, expect 1 `o_line_done` pulse and `o_line_count` = 1.
3. Send 17 bytes with FIFO_DEPTH = 16 and `i_ready` = 0. Expect `o_level` = 16, `o_overflow` = 1, and the 17th byte lost. Then pulse `i_clear_err` and expect `o_overflow` = 0.
4. Send 0x55 with the stop bit forced low, then hold the line low for 40 cycles, then release. Expect `o_framing_err` = 1, nothing pushed, and no new start until the line returns high. A following 0xA5 is received correctly.
5. Apply a 4-cycle low glitch on the idle line. Expect a return to IDLE, no push and no flags.
6. Assert `clk_uart_rst` mid-DATA of 0x3C, then deassert. Expect empty FIFO, no `o_valid`, and a subsequent 0x3C received intact.
